// File: rtl/vintc.sv
// vintc: vectored interrupt controller with per-source edge/level capture,
// fixed priority (source 0 highest), nested preemption and a claim/EOI
// register interface on the 16-bit I/O register bus.
module vintc #(
    parameter int NSRC = 8,
    parameter int RV   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic [3:0]      io_addr,
    input  logic            io_write,
    input  logic            io_read,
    input  logic [RV-1:0]   io_wdata,
    output logic [RV-1:0]   io_rdata,
    output logic            interrupt,
    output logic [3:0]      intr_id
);

    // Synchroniser stages; sync3_q is the delayed copy used for edge detect.
    logic [NSRC-1:0] sync1_q, sync2_q, sync3_q;

    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] in_service_q, in_service_d;
    logic            ctrl_q, ctrl_d;
    logic            interrupt_q, interrupt_d;
    logic [3:0]      intr_id_q, intr_id_d;

    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] below_mask;
    logic [NSRC-1:0] eligible;
    logic [3:0]      best;
    logic            valid;

    logic wr_pending, wr_enable, wr_mode, wr_eoi, wr_ctrl, rd_claim;

    // Upper write-data bits are unused when NSRC is below the bus width.
    logic unused_wdata;
    assign unused_wdata = ^io_wdata;

    assign wr_pending = io_write && (io_addr == 4'd0);
    assign wr_enable  = io_write && (io_addr == 4'd1);
    assign wr_mode    = io_write && (io_addr == 4'd2);
    assign wr_eoi     = io_write && (io_addr == 4'd4);
    assign wr_ctrl    = io_write && (io_addr == 4'd5);
    assign rd_claim   = io_read && (io_addr == 4'd3);

    assign rise = sync2_q & ~sync3_q;

    // Source synchroniser and edge-detect delay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= src;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // Mask of sources strictly above the highest-priority in-service source.
    always_comb begin : prio_mask
        logic hit;
        hit        = 1'b0;
        below_mask = '0;
        for (int i = 0; i < NSRC; i++) begin
            hit           = hit | in_service_q[i];
            below_mask[i] = ~hit;
        end
    end

    assign eligible = pending_q & enable_q & ~in_service_q & below_mask;
    assign valid    = |eligible;

    // Lowest-index eligible source wins.
    always_comb begin
        best = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                best = 4'(i);
            end
        end
    end

    // Next-state for pending, in-service, configuration and outputs.
    always_comb begin
        enable_d     = enable_q;
        mode_d       = mode_q;
        ctrl_d       = ctrl_q;
        in_service_d = in_service_q;
        clr          = '0;

        if (wr_pending) begin
            clr = io_wdata[NSRC-1:0];
        end

        for (int i = 0; i < NSRC; i++) begin
            if (rd_claim && valid && (best == 4'(i))) begin
                in_service_d[i] = 1'b1;
                clr[i]          = 1'b1;
            end
            if (wr_eoi && (io_wdata[3:0] == 4'(i))) begin
                in_service_d[i] = 1'b0;
            end
        end

        // Clears only reach edge bits; a coincident new edge wins over a clear.
        pending_d = (mode_q & (rise | (pending_q & ~clr))) | (~mode_q & sync2_q);

        if (wr_enable) begin
            enable_d = io_wdata[NSRC-1:0];
        end
        if (wr_mode) begin
            mode_d = io_wdata[NSRC-1:0];
        end
        if (wr_ctrl) begin
            ctrl_d = io_wdata[0];
        end

        interrupt_d = ctrl_q & valid;
        intr_id_d   = best;
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q    <= '0;
            enable_q     <= '0;
            mode_q       <= '0;
            in_service_q <= '0;
            ctrl_q       <= 1'b0;
            interrupt_q  <= 1'b0;
            intr_id_q    <= '0;
        end else begin
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            mode_q       <= mode_d;
            in_service_q <= in_service_d;
            ctrl_q       <= ctrl_d;
            interrupt_q  <= interrupt_d;
            intr_id_q    <= intr_id_d;
        end
    end

    assign interrupt = interrupt_q;
    assign intr_id   = intr_id_q;

    // Combinational register read mux.
    always_comb begin
        io_rdata = '0;
        case (io_addr)
            4'd0: io_rdata = RV'(pending_q);
            4'd1: io_rdata = RV'(enable_q);
            4'd2: io_rdata = RV'(mode_q);
            4'd3: begin
                io_rdata[RV-1] = valid;
                io_rdata[3:0]  = best;
            end
            4'd5: io_rdata[0] = ctrl_q;
            4'd6: io_rdata = RV'(in_service_q);
            4'd7: io_rdata = RV'(sync2_q);
            default: io_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_vintc.sv
// tb_vintc: directed vector table, hand-written corner sequences and a
// randomized run against a behavioural model of the interrupt controller.
module tb_vintc;

    localparam int N      = 8;
    localparam int K_IDLE = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;

    logic        clk;
    logic        reset;
    logic [7:0]  src;
    logic [3:0]  io_addr;
    logic        io_write;
    logic        io_read;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic        interrupt;
    logic [3:0]  intr_id;

    int n_checks = 0;
    int n_fail   = 0;

    vintc #(.NSRC(N), .RV(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .src      (src),
        .io_addr  (io_addr),
        .io_write (io_write),
        .io_read  (io_read),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .interrupt(interrupt),
        .intr_id  (intr_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  src;
        int          kind;
        logic [3:0]  addr;
        logic [15:0] wdata;
        bit          chk;
        logic [15:0] exp_rd;
        logic        exp_int;
        logic [3:0]  exp_id;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [7:0] s, int k, logic [3:0] a, logic [15:0] d, bit c,
                                logic [15:0] e, logic ei, logic [3:0] eid);
        vec_t v;
        v.src = s; v.kind = k; v.addr = a; v.wdata = d; v.chk = c;
        v.exp_rd = e; v.exp_int = ei; v.exp_id = eid;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive after the edge, check at negedge, commit at next edge.
    task automatic apply(input vec_t v, input string tag);
        src      = v.src;
        io_write = (v.kind == K_WR);
        io_read  = (v.kind == K_RD);
        io_addr  = v.addr;
        io_wdata = v.wdata;
        @(negedge clk);
        if (v.chk) check({tag, " rdata"}, io_rdata, v.exp_rd);
        check({tag, " interrupt"}, 16'(interrupt), 16'(v.exp_int));
        check({tag, " intr_id"}, 16'(intr_id), 16'(v.exp_id));
        @(posedge clk);
        #1;
        io_write = 1'b0;
        io_read  = 1'b0;
    endtask

    // Behavioural model state; hist[k] is src as sampled k edges ago.
    bit [15:0]  m_pend, m_en, m_mode, m_isv;
    bit         m_ctrl, m_int;
    int         m_id;
    logic [7:0] hist[$];

    function automatic int m_best();
        int p;
        p = N;
        for (int i = 0; i < N; i++) begin
            if (m_isv[i]) begin
                p = i;
                break;
            end
        end
        for (int i = 0; i < p; i++) begin
            if (m_pend[i] && m_en[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] m_read(int a);
        int b;
        case (a)
            0: return m_pend;
            1: return m_en;
            2: return m_mode;
            3: begin
                b = m_best();
                return (b >= 0) ? (16'h8000 | 16'(b)) : 16'h0;
            end
            5: return {15'h0, m_ctrl};
            6: return m_isv;
            7: return {8'h0, hist[1]};
            default: return 16'h0;
        endcase
    endfunction

    task automatic model_step();
        int         b;
        int         id;
        bit [15:0]  clr, newp;
        logic [7:0] lvl, rs;
        b    = m_best();
        lvl  = hist[1];
        rs   = hist[1] & ~hist[2];
        clr  = '0;
        newp = '0;
        if (io_write && io_addr == 4'd0) clr = io_wdata & m_mode;
        if (io_read && io_addr == 4'd3 && b >= 0) begin
            m_isv[b] = 1'b1;
            if (m_mode[b]) clr[b] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            newp[i] = m_mode[i] ? (rs[i] | (m_pend[i] & ~clr[i])) : lvl[i];
        end
        m_int  = m_ctrl && (b >= 0);
        m_id   = (b >= 0) ? b : 0;
        m_pend = newp;
        if (io_write) begin
            case (io_addr)
                4'd1: m_en = io_wdata & 16'h00ff;
                4'd2: m_mode = io_wdata & 16'h00ff;
                4'd5: m_ctrl = io_wdata[0];
                4'd4: begin
                    id = int'(io_wdata[3:0]);
                    if (id < N) m_isv[id] = 1'b0;
                end
                default: ;
            endcase
        end
        hist.push_front(src);
        void'(hist.pop_back());
    endtask

    initial begin
        reset = 1'b0; src = '0; io_addr = '0; io_write = 1'b0; io_read = 1'b0; io_wdata = '0;

        // Reset reads, then level, edge, nesting and empty-claim scenarios.
        for (int a = 0; a < 16; a++) tbl.push_back(mk(8'h00, K_IDLE, 4'(a), 0, 1, 0, 0, 0));
        tbl.push_back(mk(8'h00, K_WR,   4'd1, 16'h0008, 0, 0,        0, 0));
        tbl.push_back(mk(8'h00, K_WR,   4'd5, 16'h0001, 0, 0,        0, 0));
        tbl.push_back(mk(8'h00, K_WR,   4'd2, 16'h0000, 0, 0,        0, 0));
        tbl.push_back(mk(8'h08, K_IDLE, 4'd1, 0,        1, 16'h0008, 0, 0));
        tbl.push_back(mk(8'h08, K_IDLE, 4'd7, 0,        1, 16'h0000, 0, 0));
        tbl.push_back(mk(8'h08, K_IDLE, 4'd7, 0,        1, 16'h0008, 0, 0));
        tbl.push_back(mk(8'h08, K_IDLE, 4'd0, 0,        1, 16'h0008, 0, 0));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd3, 0,        1, 16'h8003, 1, 3));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd0, 0,        1, 16'h0008, 1, 3));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd0, 0,        1, 16'h0008, 1, 3));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd0, 0,        1, 16'h0000, 1, 3));
        tbl.push_back(mk(8'h00, K_WR,   4'd2, 16'h0020, 0, 0,        0, 0));
        tbl.push_back(mk(8'h00, K_WR,   4'd1, 16'h0020, 0, 0,        0, 0));
        tbl.push_back(mk(8'h20, K_IDLE, 4'd0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(8'h20, K_IDLE, 4'd0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd0, 0,        1, 16'h0000, 0, 0));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd0, 0,        1, 16'h0020, 0, 0));
        tbl.push_back(mk(8'h00, K_RD,   4'd3, 0,        1, 16'h8005, 1, 5));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd0, 0,        1, 16'h0000, 1, 5));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd6, 0,        1, 16'h0020, 0, 0));
        tbl.push_back(mk(8'h00, K_WR,   4'd4, 16'h0005, 0, 0,        0, 0));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd6, 0,        1, 16'h0000, 0, 0));
        tbl.push_back(mk(8'h00, K_WR,   4'd1, 16'h0052, 0, 0,        0, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(8'h10, K_IDLE, 4'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(8'h10, K_IDLE, 4'd0, 0,        1, 16'h0010, 0, 0));
        tbl.push_back(mk(8'h10, K_RD,   4'd3, 0,        1, 16'h8004, 1, 4));
        tbl.push_back(mk(8'h50, K_IDLE, 4'd6, 0,        1, 16'h0010, 1, 4));
        tbl.push_back(mk(8'h50, K_IDLE, 4'd0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(8'h50, K_IDLE, 4'd0, 0,        0, 0,        0, 0));
        tbl.push_back(mk(8'h50, K_IDLE, 4'd0, 0,        1, 16'h0050, 0, 0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(8'h52, K_IDLE, 4'd0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(8'h52, K_IDLE, 4'd0, 0,        1, 16'h0052, 0, 0));
        tbl.push_back(mk(8'h52, K_RD,   4'd3, 0,        1, 16'h8001, 1, 1));
        tbl.push_back(mk(8'h40, K_IDLE, 4'd6, 0,        1, 16'h0012, 1, 1));
        tbl.push_back(mk(8'h40, K_WR,   4'd4, 16'h0009, 0, 0,        0, 0));
        tbl.push_back(mk(8'h40, K_WR,   4'd4, 16'h000f, 0, 0,        0, 0));
        tbl.push_back(mk(8'h40, K_IDLE, 4'd6, 0,        1, 16'h0012, 0, 0));
        tbl.push_back(mk(8'h40, K_WR,   4'd4, 16'h0001, 0, 0,        0, 0));
        tbl.push_back(mk(8'h40, K_IDLE, 4'd6, 0,        1, 16'h0010, 0, 0));
        tbl.push_back(mk(8'h40, K_WR,   4'd4, 16'h0004, 0, 0,        0, 0));
        tbl.push_back(mk(8'h40, K_IDLE, 4'd6, 0,        1, 16'h0000, 0, 0));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd3, 0,        1, 16'h8006, 1, 6));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd0, 0,        0, 0,        1, 6));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd0, 0,        0, 0,        1, 6));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd0, 0,        1, 16'h0000, 1, 6));
        tbl.push_back(mk(8'h00, K_RD,   4'd3, 0,        1, 16'h0000, 0, 0));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd6, 0,        1, 16'h0000, 0, 0));
        tbl.push_back(mk(8'h00, K_IDLE, 4'd0, 0,        1, 16'h0000, 0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

        // W1C on a level bit, then W1C coinciding with a new edge on bit 0.
        apply(mk(8'h00, K_WR,   4'd2, 16'h0021, 0, 0,        0, 0), "w1c mode");
        apply(mk(8'h05, K_IDLE, 4'd0, 0,        0, 0,        0, 0), "w1c a0");
        apply(mk(8'h04, K_IDLE, 4'd0, 0,        0, 0,        0, 0), "w1c a1");
        apply(mk(8'h04, K_IDLE, 4'd0, 0,        0, 0,        0, 0), "w1c a2");
        apply(mk(8'h04, K_IDLE, 4'd0, 0,        1, 16'h0005, 0, 0), "w1c pend");
        apply(mk(8'h04, K_WR,   4'd0, 16'h0004, 0, 0,        0, 0), "w1c level");
        apply(mk(8'h04, K_IDLE, 4'd0, 0,        1, 16'h0005, 0, 0), "w1c level kept");
        apply(mk(8'h05, K_IDLE, 4'd0, 0,        0, 0,        0, 0), "w1c b0");
        apply(mk(8'h05, K_IDLE, 4'd0, 0,        0, 0,        0, 0), "w1c b1");
        apply(mk(8'h05, K_WR,   4'd0, 16'h0001, 0, 0,        0, 0), "w1c vs edge");
        apply(mk(8'h05, K_IDLE, 4'd0, 0,        1, 16'h0005, 0, 0), "w1c set wins");
        apply(mk(8'h05, K_WR,   4'd0, 16'h0001, 0, 0,        0, 0), "w1c edge");
        apply(mk(8'h05, K_IDLE, 4'd0, 0,        1, 16'h0004, 0, 0), "w1c cleared");

        // Build in_service=0x12 with pending set, then reset mid-operation.
        apply(mk(8'h00, K_WR,   4'd2, 16'h0000, 0, 0,        0, 0), "rst mode");
        apply(mk(8'h00, K_WR,   4'd1, 16'h0012, 0, 0,        0, 0), "rst en");
        for (int k = 0; k < 3; k++) apply(mk(8'h10, K_IDLE, 4'd0, 0, 0, 0, 0, 0), "rst w4");
        apply(mk(8'h10, K_RD,   4'd3, 0,        1, 16'h8004, 0, 0), "rst claim4");
        apply(mk(8'h12, K_IDLE, 4'd0, 0,        0, 0,        1, 4), "rst after4");
        apply(mk(8'h12, K_IDLE, 4'd0, 0,        0, 0,        0, 0), "rst w1a");
        apply(mk(8'h12, K_IDLE, 4'd0, 0,        0, 0,        0, 0), "rst w1b");
        apply(mk(8'h12, K_RD,   4'd3, 0,        1, 16'h8001, 0, 0), "rst claim1");
        io_addr = 4'd6;
        @(negedge clk);
        check("pre-reset inservice", io_rdata, 16'h0012);
        check("pre-reset interrupt", 16'(interrupt), 16'h1);
        io_addr = 4'd0;
        #1;
        check("pre-reset pending", io_rdata, 16'h0012);
        reset = 1'b0;
        #1;
        check("async reset interrupt", 16'(interrupt), 16'h0);
        check("async reset intr_id", 16'(intr_id), 16'h0);
        for (int a = 0; a < 16; a++) begin
            io_addr = 4'(a);
            #1;
            check($sformatf("async reset read%0d", a), io_rdata, 16'h0);
        end
        src = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomized run against the behavioural model.
        m_pend = '0; m_en = '0; m_mode = '0; m_isv = '0; m_ctrl = 1'b0; m_int = 1'b0; m_id = 0;
        hist = {8'h00, 8'h00, 8'h00};
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int op;
            src      = src ^ 8'($urandom & $urandom & $urandom);
            io_write = 1'b0;
            io_read  = 1'b0;
            io_addr  = 4'($urandom_range(0, 15));
            io_wdata = 16'($urandom);
            op       = $urandom_range(0, 15);
            if (op >= 6 && op <= 8) begin
                io_read = 1'b1; io_addr = 4'd3;
            end else if (op == 9 || op == 10) begin
                io_write = 1'b1; io_addr = 4'd4;
            end else if (op == 11) begin
                io_write = 1'b1; io_addr = 4'd1; io_wdata = 16'($urandom | $urandom);
            end else if (op == 12) begin
                io_write = 1'b1; io_addr = 4'd2;
            end else if (op == 13) begin
                io_write = 1'b1; io_addr = 4'd0;
            end else if (op == 14) begin
                io_write = 1'b1; io_addr = 4'd5;
                if ($urandom_range(0, 3) != 0) io_wdata[0] = 1'b1;
            end else if (op == 15) begin
                io_write = 1'b1;
            end
            @(negedge clk);
            check($sformatf("rand%0d rdata a%0d", cyc, io_addr), io_rdata,
                  m_read(int'(io_addr)));
            check($sformatf("rand%0d interrupt", cyc), 16'(interrupt), 16'(m_int));
            check($sformatf("rand%0d intr_id", cyc), 16'(intr_id), 16'(m_id));
            @(posedge clk);
            model_step();
            #1;
        end
        io_write = 1'b0;
        io_read  = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
